sgmii_an_rx_config: RTL and testbench
=====================================

# sgmii_an_rx_config

Receive-side ordered-set parser for SGMII/1000BASE-X auto-negotiation. It sits directly downstream of the 8b/10b decoder and upstream of the auto-negotiation state machine inside `entry_point`. It turns the decoded code-group stream into:
- validated config words;
- Clause 37 match flags (`ability_match`, `ack_match`, `idle_match`, `rx_cfg_zero`);
- decoded SGMII link/speed/duplex fields.

## Interface
Parameters:
- `MATCH_COUNT`, 3: number of consecutive identical ordered sets required for a match (range 2–7).

Ports:
- `clock` in 1: single clock; every input is sampled on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one decoded code-group is present this cycle.
- `rx_data` in 8: decoded octet.
- `rx_is_k` in 1: the octet is a K control code.
- `rx_code_err` in 1: the decoder flagged an invalid code-group or disparity error. Only meaningful when `rx_valid` is high.
- `cfg_word` out 16: last fully received config register (`{hi,lo}`).
- `cfg_strobe` out 1: one-cycle pulse when a new `/C/` completes.
- `ability_match` out 1: `MATCH_COUNT` consecutive `/C/` words that are identical when bit 14 is ignored.
- `ack_match` out 1: `ability_match` is high and bit 14 of the matched word is 1.
- `idle_match` out 1: `MATCH_COUNT` consecutive `/I/` sets.
- `rx_cfg_zero` out 1: `ability_match` is high and the matched word is 0x0000 (restart signalling).
- `sgmii_link` out 1: matched word bit 15.
- `sgmii_speed` out 2: matched word bits 11:10.
- `sgmii_duplex` out 1: matched word bit 12.

## Operation
Parser FSM. It advances only on cycles with `rx_valid` high.
- HUNT:
  - K28.5 (`rx_is_k`, 0xBC) -> GOT_K.
  - Anything else stays in HUNT.
- GOT_K:
  - D21.5 (0xB5) or D2.2 (0x42) -> CFG_LO.
  - D5.6 (0xC5) or D16.2 (0x50) -> HUNT, and one `/I/` is counted.
  - K28.5 -> GOT_K.
  - Any other code -> HUNT.
- CFG_LO:
  - Data octet -> store low byte, go to CFG_HI.
  - K code -> HUNT.
- CFG_HI:
  - Data octet -> complete the word, go to HUNT.
  - K code -> HUNT.

Error and abort handling:
- `rx_code_err` in any state: go to HUNT and clear both run counters.
- An aborted `/C/` (K code in CFG_LO or CFG_HI) clears the `/C/` run counter. It does not touch `idle_match`.

Word completion:
- Load `cfg_word` and pulse `cfg_strobe`.
- Compare the new word with the previous word, with bit 14 masked in both:
  - Equal: increment the `/C/` run counter, saturating at `MATCH_COUNT`.
  - Not equal: set the counter to 1.
- Clear the `/I/` run counter.

`/I/` completion: increment the `/I/` run counter (saturating) and clear the `/C/` run counter.

Flag and field outputs:
- `ability_match` = (`/C/` counter == `MATCH_COUNT`).
- `idle_match` = (`/I/` counter == `MATCH_COUNT`).
- The SGMII fields and `rx_cfg_zero` are registered from the matching word. They hold their value while `ability_match` stays high. When `ability_match` falls, the fields hold their last value and `rx_cfg_zero` clears.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in HUNT, both counters 0.
  - Previous-word register 0x0000, with a "previous valid" bit cleared so the first word never counts as a repeat.
- Latency:
  - `cfg_strobe` and `cfg_word` update on the clock edge that accepts the hi byte, so they are visible the cycle after that input cycle.
  - Match flags update on the same edge as `cfg_strobe`.
  - `idle_match` updates on the edge accepting the second `/I/` octet.
- `rx_valid` low cycles are pure stalls: no state change and no pulse.
- A `/C/` or `/I/` following immediately after the previous set, with no gap, is legal.
- Asserting `reset` mid-ordered-set discards the partial set immediately and asynchronously.

## Structure
- Package `sgmii_an_pkg` holds:
  - constants `K28_5`, `D21_5`, `D2_2`, `D5_6`, `D16_2`;
  - the parser state enum `an_rx_state_t`;
  - the config-word bit indices (`CFG_ACK_BIT`=14, `CFG_LINK_BIT`=15, `CFG_DUPLEX_BIT`=12, `CFG_SPEED_LSB`=10);
  - the speed encodings (00 = 10M, 01 = 100M, 10 = 1000M).
- One sub-module: `an_match_counter`, a saturating run counter with a compare/clear/increment interface. It is instantiated twice, once for `/C/` and once for `/I/`.

## Test plan
- Three back-to-back `/C1/ /C2/ /C1/` sets with word 0xD801 -> three `cfg_strobe` pulses; `ability_match`=1 after the 3rd, `ack_match`=1, `sgmii_link`=1, `sgmii_speed`=10, `sgmii_duplex`=1.
- Words 0x9801, 0xD801, 0x9801 -> `ability_match`=1 after the 3rd, because bit 14 is ignored; `ack_match`=0 because the 3rd word has ACK clear.
- Three `/C/` sets with 0x0000 -> `ability_match`=1 and `rx_cfg_zero`=1. A following `/I2/` -> `ability_match`=0 and `rx_cfg_zero`=0. Two more `/I2/` -> `idle_match`=1.
- Two `/C/` sets with 0x4001, then `rx_code_err` during the lo byte of the third, then three clean `/C/` sets -> `ability_match` stays 0 until the 3rd clean set completes; only the clean sets strobe.
- Random `rx_valid` stalls inserted inside the ordered sets -> same `cfg_word` sequence and flag timing (in accepted-octet count) as the unstalled run. Reset asserted in CFG_HI -> all outputs 0 immediately and no strobe.

Source files
------------

// File: rtl/sgmii_an_pkg.sv
// Shared constants, parser state type and helpers for the SGMII
// auto-negotiation receive config parser.
package sgmii_an_pkg;

    // Ordered-set code-group octets (after 8b/10b decode)
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    // Parser state
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_GOT_K  = 2'd1,
        ST_CFG_LO = 2'd2,
        ST_CFG_HI = 2'd3
    } an_rx_state_t;

    // Config-word bit positions
    localparam int CFG_ACK_BIT    = 14;
    localparam int CFG_LINK_BIT   = 15;
    localparam int CFG_DUPLEX_BIT = 12;
    localparam int CFG_SPEED_LSB  = 10;

    // SGMII speed encodings
    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    localparam logic [15:0] CFG_ACK_MASK = 16'h4000;

    // Two config words count as the same ability when they differ only in ACK
    function automatic logic cfg_words_equal(input logic [15:0] a, input logic [15:0] b);
        return ((a & ~CFG_ACK_MASK) == (b & ~CFG_ACK_MASK));
    endfunction

endpackage

// File: rtl/sgmii_an_rx_config_counter.sv
// Saturating run counter: clear wins, increment either extends the run
// (same) or restarts it at one. Match flag is registered alongside.
module an_match_counter #(
    parameter int MATCH_COUNT = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    input  logic same,
    output logic match,
    output logic match_next
);

    localparam logic [2:0] MATCH_VAL = 3'(MATCH_COUNT);

    logic [2:0] count_r;
    logic [2:0] count_next_s;

    // Next run length from clear / increment / compare result
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = 3'd0;
        end else if (incr) begin
            if (same) begin
                if (count_r < MATCH_VAL) begin
                    count_next_s = count_r + 3'd1;
                end else begin
                    count_next_s = count_r;
                end
            end else begin
                count_next_s = 3'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    assign match_next = (count_next_s == MATCH_VAL);

    // Counter and match flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 3'd0;
            match   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            match   <= match_next;
        end
    end

endmodule

// File: rtl/sgmii_an_rx_config.sv
// Receive-side /C/ and /I/ ordered-set parser for Clause 37 / SGMII
// auto-negotiation: config words, match flags and decoded SGMII fields.
module sgmii_an_rx_config
    import sgmii_an_pkg::*;
#(
    parameter int MATCH_COUNT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_is_k,
    input  logic        rx_code_err,
    output logic [15:0] cfg_word,
    output logic        cfg_strobe,
    output logic        ability_match,
    output logic        ack_match,
    output logic        idle_match,
    output logic        rx_cfg_zero,
    output logic        sgmii_link,
    output logic [1:0]  sgmii_speed,
    output logic        sgmii_duplex
);

    an_rx_state_t state_r;
    an_rx_state_t next_state_s;

    logic [7:0]  lo_byte_r;
    logic [15:0] prev_word_r;
    logic        prev_valid_r;

    logic        lo_load_s;
    logic        word_done_s;
    logic        idle_done_s;
    logic        c_abort_s;
    logic        err_s;
    logic [15:0] word_s;
    logic [15:0] match_word_s;
    logic        c_same_s;
    logic        c_match_s;
    logic        c_match_next_s;
    logic        i_match_s;
    logic        i_match_next_s;

    assign word_s = {rx_data, lo_byte_r};

    // Parser next-state and per-octet events; idle cycles change nothing
    always_comb begin
        next_state_s = state_r;
        lo_load_s    = 1'b0;
        word_done_s  = 1'b0;
        idle_done_s  = 1'b0;
        c_abort_s    = 1'b0;
        err_s        = 1'b0;
        if (rx_valid) begin
            if (rx_code_err) begin
                err_s        = 1'b1;
                next_state_s = ST_HUNT;
            end else begin
                case (state_r)
                    ST_HUNT: begin
                        if (rx_is_k && (rx_data == K28_5)) begin
                            next_state_s = ST_GOT_K;
                        end else begin
                            next_state_s = ST_HUNT;
                        end
                    end
                    ST_GOT_K: begin
                        if (rx_is_k) begin
                            if (rx_data == K28_5) begin
                                next_state_s = ST_GOT_K;
                            end else begin
                                next_state_s = ST_HUNT;
                            end
                        end else if ((rx_data == D21_5) || (rx_data == D2_2)) begin
                            next_state_s = ST_CFG_LO;
                        end else if ((rx_data == D5_6) || (rx_data == D16_2)) begin
                            next_state_s = ST_HUNT;
                            idle_done_s  = 1'b1;
                        end else begin
                            next_state_s = ST_HUNT;
                        end
                    end
                    ST_CFG_LO: begin
                        if (rx_is_k) begin
                            next_state_s = ST_HUNT;
                            c_abort_s    = 1'b1;
                        end else begin
                            next_state_s = ST_CFG_HI;
                            lo_load_s    = 1'b1;
                        end
                    end
                    ST_CFG_HI: begin
                        if (rx_is_k) begin
                            next_state_s = ST_HUNT;
                            c_abort_s    = 1'b1;
                        end else begin
                            next_state_s = ST_HUNT;
                            word_done_s  = 1'b1;
                        end
                    end
                    default: begin
                        next_state_s = ST_HUNT;
                    end
                endcase
            end
        end else begin
            next_state_s = state_r;
        end
    end

    // Parser state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // The first word after reset never counts as a repeat
    assign c_same_s = prev_valid_r && cfg_words_equal(word_s, prev_word_r);

    an_match_counter #(.MATCH_COUNT(MATCH_COUNT)) u_cfg_count (
        .clock      (clock),
        .reset      (reset),
        .clear      (err_s | c_abort_s | idle_done_s),
        .incr       (word_done_s),
        .same       (c_same_s),
        .match      (c_match_s),
        .match_next (c_match_next_s)
    );

    an_match_counter #(.MATCH_COUNT(MATCH_COUNT)) u_idle_count (
        .clock      (clock),
        .reset      (reset),
        .clear      (err_s | word_done_s),
        .incr       (idle_done_s),
        .same       (1'b1),
        .match      (i_match_s),
        .match_next (i_match_next_s)
    );

    assign ability_match = c_match_s;
    assign idle_match    = i_match_s;

    // While matched, cfg_word is the matched word; a new word replaces it
    assign match_word_s = word_done_s ? word_s : cfg_word;

    // Low byte capture and previous-word history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lo_byte_r    <= 8'h00;
            prev_word_r  <= 16'h0000;
            prev_valid_r <= 1'b0;
        end else begin
            if (lo_load_s) begin
                lo_byte_r <= rx_data;
            end
            if (word_done_s) begin
                prev_word_r  <= word_s;
                prev_valid_r <= 1'b1;
            end
        end
    end

    // Config word, strobe, ACK/zero flags and SGMII fields
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_word     <= 16'h0000;
            cfg_strobe   <= 1'b0;
            ack_match    <= 1'b0;
            rx_cfg_zero  <= 1'b0;
            sgmii_link   <= 1'b0;
            sgmii_speed  <= SPEED_10M;
            sgmii_duplex <= 1'b0;
        end else begin
            cfg_strobe  <= word_done_s;
            ack_match   <= c_match_next_s && match_word_s[CFG_ACK_BIT];
            rx_cfg_zero <= c_match_next_s && (match_word_s == 16'h0000);
            if (word_done_s) begin
                cfg_word <= word_s;
            end
            if (word_done_s && c_match_next_s) begin
                sgmii_link   <= word_s[CFG_LINK_BIT];
                sgmii_speed  <= word_s[CFG_SPEED_LSB +: 2];
                sgmii_duplex <= word_s[CFG_DUPLEX_BIT];
            end
        end
    end

endmodule

// File: tb/tb_sgmii_an_rx_config.sv
// Directed self-checking bench for sgmii_an_rx_config.
module tb_sgmii_an_rx_config;
    import sgmii_an_pkg::*;

    logic        clock;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_is_k;
    logic        rx_code_err;
    logic [15:0] cfg_word;
    logic        cfg_strobe;
    logic        ability_match;
    logic        ack_match;
    logic        idle_match;
    logic        rx_cfg_zero;
    logic        sgmii_link;
    logic [1:0]  sgmii_speed;
    logic        sgmii_duplex;

    int checks;
    int failures;

    sgmii_an_rx_config #(.MATCH_COUNT(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_is_k       (rx_is_k),
        .rx_code_err   (rx_code_err),
        .cfg_word      (cfg_word),
        .cfg_strobe    (cfg_strobe),
        .ability_match (ability_match),
        .ack_match     (ack_match),
        .idle_match    (idle_match),
        .rx_cfg_zero   (rx_cfg_zero),
        .sgmii_link    (sgmii_link),
        .sgmii_speed   (sgmii_speed),
        .sgmii_duplex  (sgmii_duplex)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted octet, optionally preceded by stall cycles carrying junk
    task automatic send_octet(input logic k, input logic [7:0] d, input logic e, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            rx_valid    = 1'b0;
            rx_is_k     = 1'($urandom_range(0, 1));
            rx_data     = 8'($urandom_range(0, 255));
            rx_code_err = 1'b0;
            @(posedge clock);
            #1;
            check("stall_no_strobe", {15'd0, cfg_strobe}, 16'd0);
        end
        rx_valid    = 1'b1;
        rx_is_k     = k;
        rx_data     = d;
        rx_code_err = e;
        @(posedge clock);
        #1;
        rx_valid    = 1'b0;
        rx_code_err = 1'b0;
    endtask

    // Full /C1/ or /C2/ set, then check the strobe and word
    task automatic send_cfg(input logic [15:0] w, input logic alt, input logic stall);
        send_octet(1'b1, K28_5, 1'b0, stall ? int'($urandom_range(0, 2)) : 0);
        check("strobe_low_mid_set", {15'd0, cfg_strobe}, 16'd0);
        send_octet(1'b0, alt ? D2_2 : D21_5, 1'b0, stall ? int'($urandom_range(0, 2)) : 0);
        send_octet(1'b0, w[7:0], 1'b0, stall ? int'($urandom_range(0, 2)) : 0);
        send_octet(1'b0, w[15:8], 1'b0, stall ? int'($urandom_range(0, 2)) : 0);
        check("cfg_strobe", {15'd0, cfg_strobe}, 16'd1);
        check("cfg_word", cfg_word, w);
    endtask

    // /I2/ set; idle flag is updated by the second octet
    task automatic send_idle(input logic alt);
        send_octet(1'b1, K28_5, 1'b0, 0);
        send_octet(1'b0, alt ? D16_2 : D5_6, 1'b0, 0);
    endtask

    task automatic check_flags(input string tag, input logic am, input logic ak,
                               input logic im, input logic cz);
        check({tag, "_ability"}, {15'd0, ability_match}, {15'd0, am});
        check({tag, "_ack"},     {15'd0, ack_match},     {15'd0, ak});
        check({tag, "_idle"},    {15'd0, idle_match},    {15'd0, im});
        check({tag, "_zero"},    {15'd0, rx_cfg_zero},   {15'd0, cz});
    endtask

    task automatic check_fields(input string tag, input logic lk, input logic [1:0] sp, input logic dx);
        check({tag, "_link"},   {15'd0, sgmii_link},   {15'd0, lk});
        check({tag, "_speed"},  {14'd0, sgmii_speed},  {14'd0, sp});
        check({tag, "_duplex"}, {15'd0, sgmii_duplex}, {15'd0, dx});
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        rx_is_k     = 1'b0;
        rx_code_err = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_word", cfg_word, 16'h0000);
        check("rst_strobe", {15'd0, cfg_strobe}, 16'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_fields("rst", 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Three D801 sets: ACK set, link up, 1000M, full duplex
        send_cfg(16'hD801, 1'b0, 1'b0);
        check_flags("t1_w1", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'hD801, 1'b1, 1'b0);
        check_flags("t1_w2", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'hD801, 1'b0, 1'b0);
        check_flags("t1_w3", 1'b1, 1'b1, 1'b0, 1'b0);
        check_fields("t1", 1'b1, 2'b10, 1'b1);
        send_octet(1'b1, K28_5, 1'b0, 0);
        check("t1_strobe_drop", {15'd0, cfg_strobe}, 16'd0);

        // An /I/ breaks the run; then ACK toggling is ignored in the compare
        send_idle(1'b1);
        check_flags("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h9801, 1'b0, 1'b0);
        check_flags("t2_w1", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'hD801, 1'b1, 1'b0);
        check_flags("t2_w2", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h9801, 1'b0, 1'b0);
        check_flags("t2_w3", 1'b1, 1'b0, 1'b0, 1'b0);
        check_fields("t2", 1'b1, 2'b10, 1'b1);

        // Restart signalling with 0x0000, then idles
        send_cfg(16'h0000, 1'b0, 1'b0);
        send_cfg(16'h0000, 1'b1, 1'b0);
        check_flags("t3_w2", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h0000, 1'b0, 1'b0);
        check_flags("t3_w3", 1'b1, 1'b0, 1'b0, 1'b1);
        check_fields("t3", 1'b0, 2'b00, 1'b0);
        send_idle(1'b1);
        check_flags("t3_i1", 1'b0, 1'b0, 1'b0, 1'b0);
        send_idle(1'b1);
        check_flags("t3_i2", 1'b0, 1'b0, 1'b0, 1'b0);
        send_idle(1'b0);
        check_flags("t3_i3", 1'b0, 1'b0, 1'b1, 1'b0);
        check_fields("t3_hold", 1'b0, 2'b00, 1'b0);

        // Code error in the lo byte of the third set restarts the run
        send_cfg(16'h4001, 1'b0, 1'b0);
        check_flags("t4_w1", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h4001, 1'b1, 1'b0);
        send_octet(1'b1, K28_5, 1'b0, 0);
        send_octet(1'b0, D21_5, 1'b0, 0);
        send_octet(1'b0, 8'h01, 1'b1, 0);
        send_octet(1'b0, 8'h40, 1'b0, 0);
        check("t4_err_no_strobe", {15'd0, cfg_strobe}, 16'd0);
        check("t4_err_word", cfg_word, 16'h4001);
        check_flags("t4_err", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h4001, 1'b0, 1'b0);
        check_flags("t4_c1", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h4001, 1'b1, 1'b0);
        check_flags("t4_c2", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h4001, 1'b0, 1'b0);
        check_flags("t4_c3", 1'b1, 1'b1, 1'b0, 1'b0);
        check_fields("t4", 1'b0, 2'b00, 1'b0);

        // Same flag timing with random stalls inside the sets: 100M, half duplex
        send_cfg(16'h0401, 1'b0, 1'b1);
        check_flags("t5_w1", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h0401, 1'b1, 1'b1);
        check_flags("t5_w2", 1'b0, 1'b0, 1'b0, 1'b0);
        send_cfg(16'h0401, 1'b0, 1'b1);
        check_flags("t5_w3", 1'b1, 1'b0, 1'b0, 1'b0);
        check_fields("t5", 1'b0, 2'b01, 1'b0);

        // Asynchronous reset while the parser waits for the hi byte
        send_octet(1'b1, K28_5, 1'b0, 0);
        send_octet(1'b0, D21_5, 1'b0, 0);
        send_octet(1'b0, 8'h55, 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_word", cfg_word, 16'h0000);
        check_flags("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_fields("t6_rst", 1'b0, 2'b00, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_octet(1'b0, 8'hAA, 1'b0, 0);
        check("t6_no_strobe", {15'd0, cfg_strobe}, 16'd0);
        check("t6_word_kept", cfg_word, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
